// File: rtl/calc_arbiter.sv
// Two-requester round-robin front end to a shared WIDTH-bit add/sub/mul/div unit.
// Valid/ready on each request port and on the response port; divide is a restoring divider.
module calc_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [WIDTH-1:0] i_req0_A,
    input  logic [WIDTH-1:0] i_req0_B,
    input  logic [1:0]       i_req0_selOperator,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [WIDTH-1:0] i_req1_A,
    input  logic [WIDTH-1:0] i_req1_B,
    input  logic [1:0]       i_req1_selOperator,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic             o_rsp_id,
    output logic             o_rsp_divZero,
    output logic             o_busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       op_reg;
    logic             id_reg;
    logic             last_grant_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] result_reg;
    logic             rsp_id_reg;
    logic             div_zero_reg;
    logic             rsp_valid_reg;

    logic             grant_any;
    logic             grant_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [1:0]       sel_op;

    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        grant_any = i_req0_valid | i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
            grant_id = ~last_grant_reg;
        end else begin
            grant_id = i_req1_valid;
        end
        sel_a  = grant_id ? i_req1_A : i_req0_A;
        sel_b  = grant_id ? i_req1_B : i_req0_B;
        sel_op = grant_id ? i_req1_selOperator : i_req0_selOperator;
    end

    // Ready is also held low during reset so every output reads 0 immediately.
    assign o_req0_ready  = (state_reg == IDLE) && !i_reset && i_req0_valid && !grant_id;
    assign o_req1_ready  = (state_reg == IDLE) && !i_reset && i_req1_valid && grant_id;
    assign o_rsp_valid   = rsp_valid_reg;
    assign o_rsp_result  = result_reg;
    assign o_rsp_id      = rsp_id_reg;
    assign o_rsp_divZero = div_zero_reg;
    assign o_busy        = (state_reg != IDLE);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   alu_res;

    always_comb begin
        prod = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};
        case (op_reg)
            OP_ADD:  alu_res = a_reg + b_reg;
            OP_SUB:  alu_res = a_reg - b_reg;
            OP_MUL:  alu_res = prod[WIDTH-1:0];
            default: alu_res = '0;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it did not go negative.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic             sub_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    always_comb begin
        rem_shift = {rem_reg, quo_reg[WIDTH-1]};
        diff      = rem_shift - {1'b0, b_reg};
        sub_ok    = ~diff[WIDTH];
        rem_next  = sub_ok ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {quo_reg[WIDTH-2:0], sub_ok};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            op_reg         <= '0;
            id_reg         <= 1'b0;
            last_grant_reg <= 1'b1;
            rem_reg        <= '0;
            quo_reg        <= '0;
            cnt_reg        <= '0;
            result_reg     <= '0;
            rsp_id_reg     <= 1'b0;
            div_zero_reg   <= 1'b0;
            rsp_valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        a_reg          <= sel_a;
                        b_reg          <= sel_b;
                        op_reg         <= sel_op;
                        id_reg         <= grant_id;
                        last_grant_reg <= grant_id;
                        rem_reg        <= '0;
                        quo_reg        <= sel_a;
                        cnt_reg        <= '0;
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_reg == OP_DIV && b_reg == '0) begin
                        result_reg    <= '0;
                        div_zero_reg  <= 1'b1;
                        rsp_id_reg    <= id_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else if (op_reg == OP_DIV) begin
                        rem_reg <= rem_next;
                        quo_reg <= quo_next;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_LAST) begin
                            result_reg    <= quo_next;
                            div_zero_reg  <= 1'b0;
                            rsp_id_reg    <= id_reg;
                            rsp_valid_reg <= 1'b1;
                            state_reg     <= RESP;
                        end
                    end else begin
                        result_reg    <= alu_res;
                        div_zero_reg  <= 1'b0;
                        rsp_id_reg    <= id_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter: single ops, divide latency, round-robin,
// response back-pressure and asynchronous reset mid-divide.
module tb_calc_arbiter;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_req0_valid = 1'b0;
    logic       o_req0_ready;
    logic [3:0] i_req0_A = 4'd0;
    logic [3:0] i_req0_B = 4'd0;
    logic [1:0] i_req0_selOperator = 2'd0;
    logic       i_req1_valid = 1'b0;
    logic       o_req1_ready;
    logic [3:0] i_req1_A = 4'd0;
    logic [3:0] i_req1_B = 4'd0;
    logic [1:0] i_req1_selOperator = 2'd0;
    logic       o_rsp_valid;
    logic       i_rsp_ready = 1'b1;
    logic [3:0] o_rsp_result;
    logic       o_rsp_id;
    logic       o_rsp_divZero;
    logic       o_busy;

    int checks = 0;
    int failures = 0;

    calc_arbiter #(.WIDTH(4)) dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_req0_valid       (i_req0_valid),
        .o_req0_ready       (o_req0_ready),
        .i_req0_A           (i_req0_A),
        .i_req0_B           (i_req0_B),
        .i_req0_selOperator (i_req0_selOperator),
        .i_req1_valid       (i_req1_valid),
        .o_req1_ready       (o_req1_ready),
        .i_req1_A           (i_req1_A),
        .i_req1_B           (i_req1_B),
        .i_req1_selOperator (i_req1_selOperator),
        .o_rsp_valid        (o_rsp_valid),
        .i_rsp_ready        (i_rsp_ready),
        .o_rsp_result       (o_rsp_result),
        .o_rsp_id           (o_rsp_id),
        .o_rsp_divZero      (o_rsp_divZero),
        .o_busy             (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic req, input logic [3:0] a, input logic [3:0] b,
                             input logic [1:0] op);
        if (!req) begin
            i_req0_valid = 1'b1; i_req0_A = a; i_req0_B = b; i_req0_selOperator = op;
        end else begin
            i_req1_valid = 1'b1; i_req1_A = a; i_req1_B = b; i_req1_selOperator = op;
        end
    endtask

    // Wait (bounded) at negedges until a response is visible; returns edges waited.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!o_rsp_valid && n < 40) begin
            @(negedge i_clk);
            n++;
        end
    endtask

    // One complete transaction with the sink always ready; called just after a negedge in IDLE.
    task automatic run_op(input string tag, input logic req, input logic [3:0] a,
                          input logic [3:0] b, input logic [1:0] op,
                          input logic [3:0] exp_res, input logic exp_dz, input int exp_lat);
        int n;
        i_rsp_ready = 1'b1;
        drive_req(req, a, b, op);
        #1;
        check({tag, "_ready0"}, 32'(o_req0_ready), 32'(!req));
        check({tag, "_ready1"}, 32'(o_req1_ready), 32'(req));
        @(negedge i_clk);
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        check({tag, "_busy"}, 32'(o_busy), 32'd1);
        wait_rsp(n);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_result"}, 32'(o_rsp_result), 32'(exp_res));
        check({tag, "_id"}, 32'(o_rsp_id), 32'(req));
        check({tag, "_divzero"}, 32'(o_rsp_divZero), 32'(exp_dz));
        $display("txn %s req=%0d a=%0d b=%0d op=%0d -> result=%0d dz=%0d lat=%0d",
                 tag, req, a, b, op, o_rsp_result, o_rsp_divZero, n);
        @(negedge i_clk);
        check({tag, "_valid_drop"}, 32'(o_rsp_valid), 32'd0);
    endtask

    initial begin
        int n;

        // Reset state
        #1;
        check("rst_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_result", 32'(o_rsp_result), 32'd0);
        check("rst_ready", 32'({o_req0_ready, o_req1_ready}), 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        check("idle_no_ready", 32'({o_req0_ready, o_req1_ready}), 32'd0);

        // Single operations and boundaries
        run_op("add7p5", 1'b0, 4'd7, 4'd5, 2'b00, 4'd12, 1'b0, 1);
        run_op("sub3m5", 1'b1, 4'd3, 4'd5, 2'b01, 4'hE, 1'b0, 1);
        run_op("mul6x3", 1'b1, 4'd6, 4'd3, 2'b10, 4'd2, 1'b0, 1);
        run_op("div13d4", 1'b0, 4'd13, 4'd4, 2'b11, 4'd3, 1'b0, 4);
        run_op("div9d0", 1'b0, 4'd9, 4'd0, 2'b11, 4'd0, 1'b1, 1);
        run_op("div15d1", 1'b1, 4'd15, 4'd1, 2'b11, 4'd15, 1'b0, 4);
        run_op("div7d15", 1'b0, 4'd7, 4'd15, 2'b11, 4'd0, 1'b0, 4);
        run_op("add15p1", 1'b1, 4'd15, 4'd1, 2'b00, 4'd0, 1'b0, 1);

        // Round-robin from a fresh pointer: req0 wins first
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        i_rsp_ready = 1'b1;
        drive_req(1'b0, 4'd1, 4'd1, 2'b00);
        drive_req(1'b1, 4'd2, 4'd2, 2'b00);
        #1;
        check("rr_first_ready0", 32'(o_req0_ready), 32'd1);
        check("rr_first_ready1", 32'(o_req1_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_rsp(n);
            check("rr_timeout", 32'(o_rsp_valid), 32'd1);
            check("rr_id", 32'(o_rsp_id), 32'(i % 2));
            check("rr_result", 32'(o_rsp_result), (i % 2 == 1) ? 32'd4 : 32'd2);
            $display("txn rr%0d id=%0d result=%0d", i, o_rsp_id, o_rsp_result);
            if (i == 3) begin
                i_req0_valid = 1'b0;
                i_req1_valid = 1'b0;
            end
            @(negedge i_clk);
            if (i < 3) begin
                check("rr_grant_ready0", 32'(o_req0_ready), 32'(i % 2 == 1));
                check("rr_grant_ready1", 32'(o_req1_ready), 32'(i % 2 == 0));
            end
        end
        check("rr_idle_busy", 32'(o_busy), 32'd0);

        // Response back-pressure with req1 waiting
        i_rsp_ready = 1'b0;
        drive_req(1'b0, 4'd3, 4'd4, 2'b00);
        @(negedge i_clk);
        i_req0_valid = 1'b0;
        drive_req(1'b1, 4'd3, 4'd3, 2'b10);
        wait_rsp(n);
        check("stall_valid_rise", 32'(o_rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("stall_valid", 32'(o_rsp_valid), 32'd1);
            check("stall_result", 32'(o_rsp_result), 32'd7);
            check("stall_id", 32'(o_rsp_id), 32'd0);
            check("stall_ready1", 32'(o_req1_ready), 32'd0);
        end
        $display("txn stall id=%0d result=%0d held 5 cycles", o_rsp_id, o_rsp_result);
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        check("stall_release_valid", 32'(o_rsp_valid), 32'd0);
        check("stall_release_ready1", 32'(o_req1_ready), 32'd1);
        @(negedge i_clk);
        i_req1_valid = 1'b0;
        wait_rsp(n);
        check("stall_next_result", 32'(o_rsp_result), 32'd9);
        check("stall_next_id", 32'(o_rsp_id), 32'd1);
        $display("txn after_stall id=%0d result=%0d", o_rsp_id, o_rsp_result);
        @(negedge i_clk);

        // Asynchronous reset during divide EXEC cycle 2
        drive_req(1'b0, 4'd13, 4'd4, 2'b11);
        @(negedge i_clk);
        i_req0_valid = 1'b0;
        @(negedge i_clk);
        #2;
        i_reset = 1'b1;
        #1;
        check("arst_valid", 32'(o_rsp_valid), 32'd0);
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_result", 32'(o_rsp_result), 32'd0);
        check("arst_id_dz", 32'({o_rsp_id, o_rsp_divZero}), 32'd0);
        check("arst_ready", 32'({o_req0_ready, o_req1_ready}), 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            check("arst_no_rsp", 32'({o_rsp_valid, o_busy}), 32'd0);
        end
        $display("txn reset_mid_div no response issued");
        drive_req(1'b0, 4'd5, 4'd6, 2'b00);
        drive_req(1'b1, 4'd1, 4'd2, 2'b00);
        #1;
        check("arst_first_ready0", 32'(o_req0_ready), 32'd1);
        check("arst_first_ready1", 32'(o_req1_ready), 32'd0);
        @(negedge i_clk);
        i_req0_valid = 1'b0;
        wait_rsp(n);
        check("arst_rsp0_id", 32'(o_rsp_id), 32'd0);
        check("arst_rsp0_result", 32'(o_rsp_result), 32'd11);
        $display("txn post_reset id=%0d result=%0d", o_rsp_id, o_rsp_result);
        @(negedge i_clk);
        @(negedge i_clk);
        i_req1_valid = 1'b0;
        wait_rsp(n);
        check("arst_rsp1_id", 32'(o_rsp_id), 32'd1);
        check("arst_rsp1_result", 32'(o_rsp_result), 32'd3);
        $display("txn post_reset id=%0d result=%0d", o_rsp_id, o_rsp_result);
        @(negedge i_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_arbiter.md
Name: calc_arbiter

Overview:
Shares one 4-bit add/sub/mul/div calculator datapath between two requesters. Uses round-robin arbitration, a valid/ready handshake on each request port and on the single response port, and a small FSM to sequence each operation. Add, sub and mul finish in one execute cycle. Divide runs as a multi-cycle restoring divider. Sits between operand sources (e.g. keypad/UART front ends) and the result display/sink.

Parameters:
WIDTH, 4, operand/result width in bits (all arithmetic modulo 2^WIDTH)

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_req0_valid  input  1  requester 0 has an operation pending
o_req0_ready  output  1  requester 0 operation accepted this cycle
i_req0_A  input  WIDTH  requester 0 operand A
i_req0_B  input  WIDTH  requester 0 operand B
i_req0_selOperator  input  2  requester 0 op: 00 add, 01 sub, 10 mul, 11 div
i_req1_valid  input  1  requester 1 valid
o_req1_ready  output  1  requester 1 ready
i_req1_A  input  WIDTH  requester 1 operand A
i_req1_B  input  WIDTH  requester 1 operand B
i_req1_selOperator  input  2  requester 1 op
o_rsp_valid  output  1  response available
i_rsp_ready  input  1  sink accepts response
o_rsp_result  output  WIDTH  operation result
o_rsp_id  output  1  requester that issued this result
o_rsp_divZero  output  1  result came from divide with B==0
o_busy  output  1  high in any state other than IDLE

Behaviour:
- One clock domain, i_clk. i_reset is asynchronous and active-high.
- Reset (async, takes effect immediately):
  - State goes to IDLE.
  - All outputs go to 0.
  - Round-robin pointer last_grant=1, so requester 0 wins the first contention.
  - Internal operand and divider registers clear.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - o_reqN_ready is combinational and asserts only for the granted requester.
  - Grant: if only one valid is high, grant that requester. If both are high, grant the requester != last_grant.
  - Handshake happens at the rising edge where valid&ready. On that edge: capture A, B, op and id; set last_grant=id; go to EXEC.
  - With no valid high, stay in IDLE; both readies stay 0.
- Ready is never asserted outside IDLE. Requests arriving in EXEC/RESP wait, and requesters must hold valid and operands stable until ready.
- EXEC, add/sub/mul:
  - One cycle. The result register is loaded with (A op B) mod 2^WIDTH; divZero=0.
  - Go to RESP.
- EXEC, div with B!=0:
  - Restoring divider, one quotient bit per cycle, MSB first.
  - Exactly WIDTH cycles in EXEC, then load quotient = floor(A/B); divZero=0; go to RESP.
  - Remainder is discarded.
- EXEC, div with B==0: one cycle; result=0, divZero=1; go to RESP.
- RESP:
  - o_rsp_valid=1. o_rsp_result, o_rsp_id and o_rsp_divZero are registered and held stable until the handshake.
  - At the edge with i_rsp_ready=1: o_rsp_valid goes to 0 and state goes to IDLE.
  - A new grant is possible in the first IDLE cycle after that edge.
- Latency, counted from the request-handshake edge to o_rsp_valid high:
  - 1 edge for add/sub/mul and div-by-zero.
  - WIDTH edges for div.
- Minimum issue interval: 3 cycles for 1-cycle ops, WIDTH+2 cycles for div, assuming i_rsp_ready is held high.
- Holding i_rsp_ready at 0 stalls indefinitely in RESP. No request is accepted and no response output changes.
- o_rsp_result/o_rsp_id/o_rsp_divZero hold their last values after a response handshake until the next load. They are valid only while o_rsp_valid=1.
- Reset mid-operation abandons the operation: no response is issued and the pointer reinitialises.
- Changes to i_reqN_* after capture do not affect an operation in flight.

Test Plan:
- req0 A=7, B=5, op=00, sink ready -> o_req0_ready pulses 1 cycle; o_rsp_valid high 1 edge later; result=12, id=0, divZero=0.
- req1 sub A=3, B=5 -> result=14 (4'hE). Then req1 mul A=6, B=3 -> result=2 (18 mod 16); id=1 both times.
- req0 div A=13, B=4 -> o_rsp_valid rises exactly 4 edges after the handshake; result=3. Then div A=9, B=0 -> valid after 1 edge, result=0, divZero=1.
- Both requesters valid continuously with distinct ops (req0 add 1+1, req1 add 2+2), sink always ready -> grants alternate, starting with req0. Responses alternate id 0,1,0,1 with results 2,4,2,4; never two consecutive grants to the same requester.
- Sink holds i_rsp_ready=0 for 5 cycles during RESP while req1 is valid -> o_rsp_valid, result and id stay stable and o_req1_ready stays 0. Releasing ready completes the handshake, and req1 is granted in the following IDLE cycle.
- i_reset pulsed mid-div (EXEC cycle 2), asynchronous to the clock edge -> all outputs 0 immediately and no response appears. Then both valid at once -> req0 is granted first.
